// File: rtl/ll_pkg.sv
// Shared linked-list engine types: default widths, the read and write controller
// state types, and the null pointer value.
package ll_pkg;

  localparam int LL_PTR_WD     = 5;
  localparam int LL_WR_DATA_WD = 32;

  localparam logic [31:0] LL_NULL_PTR = '0;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ_PTR,
    RD_DATA_MEM,
    RD_DONE
  } t_rd_ctrl_st;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ALLOC_PTR,
    WR_DATA_MEM,
    WR_DONE
  } t_wr_ctrl_st;

endpackage

// File: rtl/ll_wr_timeout.sv
// Watchdog counter for the write controller's wait states. It is instantiated
// only when LL_WR_TIMEOUT_EN is defined. TIMEOUT_CYC must be at least 2.
module ll_wr_timeout #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_start,
  input  logic i_run,
  output logic o_expired
);

  localparam int CNT_WD = $clog2(TIMEOUT_CYC);

  logic [CNT_WD-1:0] r_cnt;
  logic              w_expired;

  assign w_expired = (r_cnt == CNT_WD'(TIMEOUT_CYC - 1));
  assign o_expired = w_expired;

  // The count saturates at the limit. The FSM leaves the wait state on that
  // same edge, so the counter never wraps back to a value that looks fresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_run && !w_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ll_wr_ctrl.sv
// Write-side controller of the linked-list engine: allocate/link a node, write the
// payload to data memory, then report completion. Define LL_WR_TIMEOUT_EN to add a watchdog.
module ll_wr_ctrl
  import ll_pkg::*;
#(
  parameter int PTR_WD      = LL_PTR_WD,
  parameter int WR_DATA_WD  = LL_WR_DATA_WD,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_req_vld,
  input  logic                  wr_req_push,
  input  logic [PTR_WD-1:0]     wr_node_at_pos,
  input  logic [WR_DATA_WD-1:0] wr_data,
  input  logic                  ll_full,
  output logic                  req_vld_to_nxt_ptr,
  output logic                  req_push_to_nxt_ptr,
  output logic [PTR_WD-1:0]     node_at_pos_to_nxt_ptr,
  input  logic                  wr_nxt_ptr_vld,
  input  logic [PTR_WD-1:0]     wr_ptr_from_nxt_ptr,
  output logic                  wr_req_to_mem_vld,
  output logic [PTR_WD-1:0]     wr_req_addr_to_mem,
  output logic [WR_DATA_WD-1:0] wr_data_to_mem,
  input  logic                  wr_ack_from_mem,
  output logic                  wr_ctrl_ready,
  output logic                  wr_done_vld,
  output logic                  wr_done_err,
  output logic [PTR_WD-1:0]     wr_done_ptr
);

  t_wr_ctrl_st r_state;
  t_wr_ctrl_st w_nxt_state;

  logic                  r_push;
  logic [PTR_WD-1:0]     r_pos;
  logic [WR_DATA_WD-1:0] r_data;
  logic [PTR_WD-1:0]     r_ptr;
  logic                  r_req_vld;
  logic                  r_mem_vld;
  logic                  r_ready;
  logic                  r_done_vld;
  logic                  r_done_err;
  logic [PTR_WD-1:0]     r_done_ptr;

  logic                  w_accept;
  logic                  w_ptr_load;
  logic                  w_done_err;
  logic [PTR_WD-1:0]     w_done_ptr;
  logic                  w_timeout;

  assign w_accept = wr_req_vld & r_ready;

`ifdef LL_WR_TIMEOUT_EN
  logic w_to_start;
  logic w_to_run;

  // Restart the count on every entry into a wait state, including the
  // direct hop from ALLOC_PTR to WR_DATA_MEM.
  assign w_to_start = (w_nxt_state != r_state) &&
                      ((w_nxt_state == WR_ALLOC_PTR) || (w_nxt_state == WR_DATA_MEM));
  assign w_to_run   = (r_state == WR_ALLOC_PTR) || (r_state == WR_DATA_MEM);

  ll_wr_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_to_start),
    .i_run    (w_to_run),
    .o_expired(w_timeout)
  );
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    w_nxt_state = r_state;
    w_ptr_load  = 1'b0;
    w_done_err  = 1'b0;
    w_done_ptr  = PTR_WD'(LL_NULL_PTR);
    case (r_state)
      WR_IDLE: begin
        if (w_accept) begin
          if (ll_full) begin
            w_nxt_state = WR_DONE;
            w_done_err  = 1'b1;
          end else begin
            w_nxt_state = WR_ALLOC_PTR;
          end
        end
      end
      WR_ALLOC_PTR: begin
        // An arriving response takes priority over a timeout on the same edge.
        if (wr_nxt_ptr_vld) begin
          w_nxt_state = WR_DATA_MEM;
          w_ptr_load  = 1'b1;
        end else if (w_timeout) begin
          w_nxt_state = WR_DONE;
          w_done_err  = 1'b1;
        end
      end
      WR_DATA_MEM: begin
        if (wr_ack_from_mem) begin
          w_nxt_state = WR_DONE;
          w_done_ptr  = r_ptr;
        end else if (w_timeout) begin
          w_nxt_state = WR_DONE;
          w_done_err  = 1'b1;
        end
      end
      WR_DONE: begin
        w_nxt_state = WR_IDLE;
      end
      default: begin
        w_nxt_state = WR_IDLE;
      end
    endcase
  end

  // Each output is a flop loaded from the next-state decode. The outputs
  // therefore change on the same edge as the state, with no combinational path to a pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= WR_IDLE;
      r_push     <= 1'b0;
      r_pos      <= '0;
      r_data     <= '0;
      r_ptr      <= '0;
      r_req_vld  <= 1'b0;
      r_mem_vld  <= 1'b0;
      r_ready    <= 1'b1;
      r_done_vld <= 1'b0;
      r_done_err <= 1'b0;
      r_done_ptr <= '0;
    end else begin
      // NOTE: non-blocking assignments only in clocked blocks, so every flop samples
      // the values from before the edge regardless of statement order.
      r_state    <= w_nxt_state;
      r_ready    <= (w_nxt_state == WR_IDLE);
      r_req_vld  <= (w_nxt_state == WR_ALLOC_PTR);
      r_mem_vld  <= (w_nxt_state == WR_DATA_MEM);
      r_done_vld <= (w_nxt_state == WR_DONE);
      r_done_err <= w_done_err;
      r_done_ptr <= w_done_ptr;
      if (w_accept) begin
        r_push <= wr_req_push;
        r_pos  <= wr_node_at_pos;
        r_data <= wr_data;
      end
      if (w_ptr_load) begin
        r_ptr <= wr_ptr_from_nxt_ptr;
      end
    end
  end

  assign req_vld_to_nxt_ptr     = r_req_vld;
  assign req_push_to_nxt_ptr    = r_push;
  assign node_at_pos_to_nxt_ptr = r_pos;
  assign wr_req_to_mem_vld      = r_mem_vld;
  assign wr_req_addr_to_mem     = r_ptr;
  assign wr_data_to_mem         = r_data;
  assign wr_ctrl_ready          = r_ready;
  assign wr_done_vld            = r_done_vld;
  assign wr_done_err            = r_done_err;
  assign wr_done_ptr            = r_done_ptr;

endmodule

// File: tb/tb_ll_wr_ctrl.sv
// Self-checking bench for ll_wr_ctrl: table-driven transactions plus hand-written
// sequences for back-to-back requests, reset during a write, and the watchdog.
module tb_ll_wr_ctrl;

  localparam int PTR_WD     = 5;
  localparam int WR_DATA_WD = 32;
  localparam int TO_CYC     = 8;

  logic                  clk;
  logic                  reset_n;
  logic                  wr_req_vld;
  logic                  wr_req_push;
  logic [PTR_WD-1:0]     wr_node_at_pos;
  logic [WR_DATA_WD-1:0] wr_data;
  logic                  ll_full;
  logic                  req_vld_to_nxt_ptr;
  logic                  req_push_to_nxt_ptr;
  logic [PTR_WD-1:0]     node_at_pos_to_nxt_ptr;
  logic                  wr_nxt_ptr_vld;
  logic [PTR_WD-1:0]     wr_ptr_from_nxt_ptr;
  logic                  wr_req_to_mem_vld;
  logic [PTR_WD-1:0]     wr_req_addr_to_mem;
  logic [WR_DATA_WD-1:0] wr_data_to_mem;
  logic                  wr_ack_from_mem;
  logic                  wr_ctrl_ready;
  logic                  wr_done_vld;
  logic                  wr_done_err;
  logic [PTR_WD-1:0]     wr_done_ptr;

  int n_total = 0;
  int n_pass  = 0;

  ll_wr_ctrl #(
    .PTR_WD     (PTR_WD),
    .WR_DATA_WD (WR_DATA_WD),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .wr_req_vld            (wr_req_vld),
    .wr_req_push           (wr_req_push),
    .wr_node_at_pos        (wr_node_at_pos),
    .wr_data               (wr_data),
    .ll_full               (ll_full),
    .req_vld_to_nxt_ptr    (req_vld_to_nxt_ptr),
    .req_push_to_nxt_ptr   (req_push_to_nxt_ptr),
    .node_at_pos_to_nxt_ptr(node_at_pos_to_nxt_ptr),
    .wr_nxt_ptr_vld        (wr_nxt_ptr_vld),
    .wr_ptr_from_nxt_ptr   (wr_ptr_from_nxt_ptr),
    .wr_req_to_mem_vld     (wr_req_to_mem_vld),
    .wr_req_addr_to_mem    (wr_req_addr_to_mem),
    .wr_data_to_mem        (wr_data_to_mem),
    .wr_ack_from_mem       (wr_ack_from_mem),
    .wr_ctrl_ready         (wr_ctrl_ready),
    .wr_done_vld           (wr_done_vld),
    .wr_done_err           (wr_done_err),
    .wr_done_ptr           (wr_done_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [4:0]  pos;
    logic [31:0] data;
    logic        full;
    int          ptr_dly;
    logic [4:0]  alloc;
    int          ack_dly;
    logic        exp_err;
    logic [4:0]  exp_ptr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic wait_ready();
    int k;
    for (k = 0; k < 20; k++) begin
      if (wr_ctrl_ready) break;
      @(negedge clk);
    end
    check("wait_ready_bound", 64'(k < 20), 64'(1));
  endtask

  // One complete transaction. Entered and left at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v);
    logic got_done;
    logic bad;
    wait_ready();
    wr_req_vld     = 1'b1;
    wr_req_push    = v.push;
    wr_node_at_pos = v.pos;
    wr_data        = v.data;
    ll_full        = v.full;
    @(negedge clk);
    wr_req_vld = 1'b0;
    wr_data    = 32'h0;
    check("ready_low_after_accept", 64'(wr_ctrl_ready), 64'(0));
    if (v.full) begin
      got_done = 1'b0;
      bad      = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (req_vld_to_nxt_ptr || wr_req_to_mem_vld) bad = 1'b1;
        if (wr_done_vld) begin
          got_done = 1'b1;
          check("full_done_err", 64'(wr_done_err), 64'(1));
          check("full_done_ptr", 64'(wr_done_ptr), 64'(0));
          break;
        end
        @(negedge clk);
      end
      check("full_done_seen", 64'(got_done), 64'(1));
      check("full_no_req_or_mem", 64'(bad), 64'(0));
    end else begin
      check("req_vld_high", 64'(req_vld_to_nxt_ptr), 64'(1));
      check("req_push", 64'(req_push_to_nxt_ptr), 64'(v.push));
      check("req_pos", 64'(node_at_pos_to_nxt_ptr), 64'(v.pos));
      wr_node_at_pos = ~v.pos;
      wr_req_push    = ~v.push;
      for (int d = 0; d < v.ptr_dly; d++) begin
        wr_ack_from_mem = 1'b1;
        @(negedge clk);
        wr_ack_from_mem = 1'b0;
        check("req_vld_held", 64'(req_vld_to_nxt_ptr), 64'(1));
        check("req_pos_held", 64'(node_at_pos_to_nxt_ptr), 64'(v.pos));
        check("req_push_held", 64'(req_push_to_nxt_ptr), 64'(v.push));
        check("stray_ack_ignored", 64'(wr_req_to_mem_vld), 64'(0));
      end
      wr_nxt_ptr_vld      = 1'b1;
      wr_ptr_from_nxt_ptr = v.alloc;
      @(negedge clk);
      wr_nxt_ptr_vld = 1'b0;
      check("req_vld_dropped", 64'(req_vld_to_nxt_ptr), 64'(0));
      check("mem_vld_high", 64'(wr_req_to_mem_vld), 64'(1));
      check("mem_addr", 64'(wr_req_addr_to_mem), 64'(v.alloc));
      check("mem_data", 64'(wr_data_to_mem), 64'(v.data));
      for (int d = 0; d < v.ack_dly; d++) begin
        wr_nxt_ptr_vld      = 1'b1;
        wr_ptr_from_nxt_ptr = ~v.alloc;
        @(negedge clk);
        wr_nxt_ptr_vld = 1'b0;
        check("mem_vld_held", 64'(wr_req_to_mem_vld), 64'(1));
        check("mem_addr_held", 64'(wr_req_addr_to_mem), 64'(v.alloc));
      end
      wr_ack_from_mem = 1'b1;
      @(negedge clk);
      wr_ack_from_mem = 1'b0;
      check("mem_vld_dropped", 64'(wr_req_to_mem_vld), 64'(0));
      check("done_vld", 64'(wr_done_vld), 64'(1));
      check("done_err", 64'(wr_done_err), 64'(v.exp_err));
      check("done_ptr", 64'(wr_done_ptr), 64'(v.exp_ptr));
    end
    @(negedge clk);
    check("done_one_cycle", 64'(wr_done_vld), 64'(0));
    check("ready_back", 64'(wr_ctrl_ready), 64'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(wr_ctrl_ready), 64'(1));
    check({tag, "_req_vld"}, 64'(req_vld_to_nxt_ptr), 64'(0));
    check({tag, "_req_push"}, 64'(req_push_to_nxt_ptr), 64'(0));
    check({tag, "_req_pos"}, 64'(node_at_pos_to_nxt_ptr), 64'(0));
    check({tag, "_mem_vld"}, 64'(wr_req_to_mem_vld), 64'(0));
    check({tag, "_mem_addr"}, 64'(wr_req_addr_to_mem), 64'(0));
    check({tag, "_mem_data"}, 64'(wr_data_to_mem), 64'(0));
    check({tag, "_done_vld"}, 64'(wr_done_vld), 64'(0));
    check({tag, "_done_err"}, 64'(wr_done_err), 64'(0));
    check({tag, "_done_ptr"}, 64'(wr_done_ptr), 64'(0));
  endtask

  initial begin
    vecs[0] = '{push: 1'b1, pos: 5'd9,  data: 32'hDEAD_BEEF, full: 1'b0, ptr_dly: 2,
                alloc: 5'd7,  ack_dly: 0, exp_err: 1'b0, exp_ptr: 5'd7};
    vecs[1] = '{push: 1'b0, pos: 5'd3,  data: 32'h1234_5678, full: 1'b0, ptr_dly: 3,
                alloc: 5'd0,  ack_dly: 2, exp_err: 1'b0, exp_ptr: 5'd0};
    vecs[2] = '{push: 1'b1, pos: 5'd0,  data: 32'hAAAA_5555, full: 1'b1, ptr_dly: 0,
                alloc: 5'd0,  ack_dly: 0, exp_err: 1'b1, exp_ptr: 5'd0};
    vecs[3] = '{push: 1'b0, pos: 5'd31, data: 32'hFFFF_FFFF, full: 1'b0, ptr_dly: 0,
                alloc: 5'd31, ack_dly: 1, exp_err: 1'b0, exp_ptr: 5'd31};

    reset_n             = 1'b0;
    wr_req_vld          = 1'b0;
    wr_req_push         = 1'b0;
    wr_node_at_pos      = '0;
    wr_data             = '0;
    ll_full             = 1'b0;
    wr_nxt_ptr_vld      = 1'b0;
    wr_ptr_from_nxt_ptr = '0;
    wr_ack_from_mem     = 1'b0;
    #12;
    check_reset_values("rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("idle");

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i]);
    end

    // Responses that arrive while idle must not start anything.
    wr_nxt_ptr_vld      = 1'b1;
    wr_ptr_from_nxt_ptr = 5'd5;
    wr_ack_from_mem     = 1'b1;
    @(negedge clk);
    wr_nxt_ptr_vld  = 1'b0;
    wr_ack_from_mem = 1'b0;
    check("idle_stray_ready", 64'(wr_ctrl_ready), 64'(1));
    check("idle_stray_req", 64'(req_vld_to_nxt_ptr), 64'(0));
    check("idle_stray_mem", 64'(wr_req_to_mem_vld), 64'(0));
    check("idle_stray_done", 64'(wr_done_vld), 64'(0));

    // Back-to-back: wr_req_vld stays high, so the second request is taken at E4.
    wr_req_vld  = 1'b1;
    wr_req_push = 1'b1;
    wr_data     = 32'h1111_1111;
    ll_full     = 1'b0;
    @(negedge clk);
    check("b2b_first_req", 64'(req_vld_to_nxt_ptr), 64'(1));
    wr_data             = 32'h2222_2222;
    wr_nxt_ptr_vld      = 1'b1;
    wr_ptr_from_nxt_ptr = 5'd4;
    @(negedge clk);
    wr_nxt_ptr_vld  = 1'b0;
    wr_ack_from_mem = 1'b1;
    check("b2b_first_mem_data", 64'(wr_data_to_mem), 64'(32'h1111_1111));
    @(negedge clk);
    wr_ack_from_mem = 1'b0;
    check("b2b_first_done", 64'(wr_done_vld), 64'(1));
    check("b2b_first_ptr", 64'(wr_done_ptr), 64'(4));
    check("b2b_no_early_accept", 64'(req_vld_to_nxt_ptr), 64'(0));
    @(negedge clk);
    check("b2b_ready_e3", 64'(wr_ctrl_ready), 64'(1));
    check("b2b_not_yet_req", 64'(req_vld_to_nxt_ptr), 64'(0));
    @(negedge clk);
    wr_req_vld = 1'b0;
    check("b2b_second_accepted", 64'(wr_ctrl_ready), 64'(0));
    check("b2b_second_req", 64'(req_vld_to_nxt_ptr), 64'(1));
    wr_nxt_ptr_vld      = 1'b1;
    wr_ptr_from_nxt_ptr = 5'd6;
    @(negedge clk);
    wr_nxt_ptr_vld  = 1'b0;
    wr_ack_from_mem = 1'b1;
    check("b2b_second_mem_data", 64'(wr_data_to_mem), 64'(32'h2222_2222));
    @(negedge clk);
    wr_ack_from_mem = 1'b0;
    check("b2b_second_ptr", 64'(wr_done_ptr), 64'(6));
    @(negedge clk);

    // Reset while waiting for the memory ack.
    wr_req_vld  = 1'b1;
    wr_req_push = 1'b1;
    wr_data     = 32'h0BAD_F00D;
    @(negedge clk);
    wr_req_vld          = 1'b0;
    wr_nxt_ptr_vld      = 1'b1;
    wr_ptr_from_nxt_ptr = 5'd9;
    @(negedge clk);
    wr_nxt_ptr_vld = 1'b0;
    check("pre_rst_mem_vld", 64'(wr_req_to_mem_vld), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0]);

    // Watchdog: no allocation response ever arrives.
    wait_ready();
    wr_req_vld  = 1'b1;
    wr_req_push = 1'b1;
    wr_data     = 32'hCAFE_0001;
    @(negedge clk);
    wr_req_vld = 1'b0;
    begin
      int done_at;
      done_at = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (wr_done_vld) begin
          done_at = k;
          break;
        end
      end
`ifdef LL_WR_TIMEOUT_EN
      check("to_done_cycle", 64'(done_at), 64'(TO_CYC));
      check("to_done_err", 64'(wr_done_err), 64'(1));
      check("to_done_ptr", 64'(wr_done_ptr), 64'(0));
      check("to_req_dropped", 64'(req_vld_to_nxt_ptr), 64'(0));
      @(negedge clk);
      check("to_ready_back", 64'(wr_ctrl_ready), 64'(1));
`else
      check("nto_no_done", 64'(done_at), 64'(0));
      check("nto_still_req", 64'(req_vld_to_nxt_ptr), 64'(1));
      check("nto_not_ready", 64'(wr_ctrl_ready), 64'(0));
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
`endif
    end
    run_vec(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "global timeout");
  end

endmodule
